// File: rtl/nano_line_mem_resp_if.sv
// Line-wide request/response bus between the NanoCache update path and its memory responder.
// The requester drives a whole 8-word line; the responder grants and returns read lines.
interface nano_line_mem_resp_if;
   logic                mm_rden;
   logic                mm_wren;
   logic [31:0]         mm_addr;
   logic [7:0][31:0]    mm_wdata;
   logic [7:0][3:0]     mm_wstrb;
   logic                mm_gnt;
   logic [7:0][31:0]    mm_rdata;
   logic                mm_rvalid;

   modport master (
      output mm_rden, mm_wren, mm_addr, mm_wdata, mm_wstrb,
      input  mm_gnt, mm_rdata, mm_rvalid
   );

   modport slave (
      input  mm_rden, mm_wren, mm_addr, mm_wdata, mm_wstrb,
      output mm_gnt, mm_rdata, mm_rvalid
   );
endinterface

// File: rtl/nano_line_mem_resp.sv
// Line memory responder: serialises one 8-word line read or write per request onto a
// single-word synchronous SRAM port and returns assembled read lines with an rvalid pulse.
module nano_line_mem_resp #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic                i_clk,
   input  logic                i_rst,
   nano_line_mem_resp_if.slave mm,
   output logic                o_sram_en,
   output logic [3:0]          o_sram_we,
   output logic [ADDR_W-1:0]   o_sram_addr,
   output logic [31:0]         o_sram_wdata,
   input  logic [31:0]         i_sram_rdata
);

   typedef enum logic [2:0] {StIdle, StWr, StRd, StRdLast, StResp} state_e;

   state_e              state_q, state_d;
   logic [2:0]          beat_q, beat_d;
   logic [ADDR_W-4:0]   line_q, line_d;
   logic [7:0][31:0]    wdata_q, wdata_d;
   logic [7:0][3:0]     wstrb_q, wstrb_d;

   logic                gnt_q, gnt_d;
   logic                rvalid_q, rvalid_d;
   logic                sram_en_q, sram_en_d;
   logic [3:0]          sram_we_q, sram_we_d;
   logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
   logic [31:0]         sram_wdata_q, sram_wdata_d;
   logic [7:0][31:0]    rdata_q, rdata_d;
   logic [2:0]          cap_idx;

   // Byte offset within the line and bits above the SRAM range carry no information.
   logic unused_addr;
   assign unused_addr = ^{mm.mm_addr[31:ADDR_W+2], mm.mm_addr[4:0]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         line_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         gnt_q        <= 1'b0;
         rvalid_q     <= 1'b0;
         sram_en_q    <= 1'b0;
         sram_we_q    <= '0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         line_q       <= line_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         gnt_q        <= gnt_d;
         rvalid_q     <= rvalid_d;
         sram_en_q    <= sram_en_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   // Write wins over a simultaneous read; the read is simply not granted.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      line_d  = line_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      case (state_q)
         StIdle: begin
            beat_d = '0;
            if (mm.mm_wren) begin
               state_d = StWr;
               line_d  = mm.mm_addr[ADDR_W+1:5];
               wdata_d = mm.mm_wdata;
               wstrb_d = mm.mm_wstrb;
            end else if (mm.mm_rden) begin
               state_d = StRd;
               line_d  = mm.mm_addr[ADDR_W+1:5];
            end
         end
         StWr: begin
            beat_d = beat_q + 3'd1;
            if (beat_q == 3'd7) state_d = StIdle;
         end
         StRd: begin
            beat_d = beat_q + 3'd1;
            if (beat_q == 3'd7) state_d = StRdLast;
         end
         StRdLast: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // SRAM controls are precomputed from the next state so they register alongside it.
   always_comb begin
      gnt_d        = (state_q == StIdle) && (mm.mm_wren || mm.mm_rden);
      rvalid_d     = (state_d == StResp);
      sram_en_d    = 1'b0;
      sram_we_d    = '0;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      if (state_d == StWr) begin
         sram_en_d    = |wstrb_d[beat_d];
         sram_we_d    = wstrb_d[beat_d];
         sram_addr_d  = {line_d, beat_d};
         sram_wdata_d = wdata_d[beat_d];
      end else if (state_d == StRd) begin
         sram_en_d   = 1'b1;
         sram_addr_d = {line_d, beat_d};
      end
      // Read data lags its access by one beat; beat has wrapped to 0 in StRdLast.
      cap_idx = beat_q - 3'd1;
      rdata_d = rdata_q;
      if ((state_q == StRd && beat_q != 3'd0) || state_q == StRdLast) begin
         rdata_d[cap_idx] = i_sram_rdata;
      end
   end

   assign mm.mm_gnt    = gnt_q;
   assign mm.mm_rvalid = rvalid_q;
   assign mm.mm_rdata  = rdata_q;
   assign o_sram_en    = sram_en_q;
   assign o_sram_we    = sram_we_q;
   assign o_sram_addr  = sram_addr_q;
   assign o_sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_nano_line_mem_resp.sv
// Bench for nano_line_mem_resp: directed and random line transactions against a word-array
// reference memory, with a behavioural SRAM attached to the DUT's SRAM port.
module tb_nano_line_mem_resp;
   localparam int unsigned AW = 14;

   bit clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            sram_en;
   logic [3:0]      sram_we;
   logic [AW-1:0]   sram_addr;
   logic [31:0]     sram_wdata;
   logic [31:0]     sram_rdata;

   logic            bd_en;
   logic [AW-1:0]   bd_addr;
   logic [31:0]     bd_data;

   bit [31:0]       mem     [0:(1<<AW)-1];
   bit [31:0]       ref_mem [0:(1<<AW)-1];

   int              checks = 0;
   int              errors = 0;
   logic [7:0][31:0] last_rdata;

   nano_line_mem_resp_if mm_if ();

   nano_line_mem_resp #(.ADDR_W(AW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .mm           (mm_if),
      .o_sram_en    (sram_en),
      .o_sram_we    (sram_we),
      .o_sram_addr  (sram_addr),
      .o_sram_wdata (sram_wdata),
      .i_sram_rdata (sram_rdata)
   );

   // Behavioural SRAM: read data appears the cycle after the enable; bd_* is a backdoor.
   always @(posedge clk) begin
      if (bd_en) begin
         mem[bd_addr] <= bd_data;
      end else if (sram_en) begin
         if (sram_we == 4'h0) begin
            sram_rdata <= mem[sram_addr];
         end else begin
            for (int k = 0; k < 4; k++)
               if (sram_we[k]) mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int unsigned waddr, input logic [31:0] data);
      bd_en   = 1'b1;
      bd_addr = AW'(waddr);
      bd_data = data;
      @(posedge clk); #1;
      bd_en   = 1'b0;
      ref_mem[waddr] = data;
   endtask

   task automatic check_quiet(input string tag);
      check(tag, {mm_if.mm_gnt, mm_if.mm_rvalid, sram_en, sram_we, sram_addr, sram_wdata}, '0);
      check({tag, " rdata"}, mm_if.mm_rdata, '0);
   endtask

   // Called just after a sample point; that cycle becomes cycle 0 of the transaction.
   task automatic line_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [7:0][31:0] wd, input logic [7:0][3:0] ws,
                           input int hold);
      int n_cyc, gnt_cnt, gnt_at, rv_cnt, rv_at, b;
      int unsigned base;
      logic exp_en;
      logic [3:0] exp_we;
      logic [AW-1:0] exp_a, obs_a;
      logic [31:0] exp_wd, obs_wd;
      logic [7:0][31:0] exp_line, rv_line;
      n_cyc   = wr ? 9 : 11;
      base    = ((addr >> 5) * 8) % (1 << AW);
      gnt_cnt = 0; gnt_at = -1; rv_cnt = 0; rv_at = -1;
      rv_line = '0;
      for (int i = 0; i < 8; i++) exp_line[i] = ref_mem[base + i];
      mm_if.mm_rden  = rd;
      mm_if.mm_wren  = wr;
      mm_if.mm_addr  = addr;
      mm_if.mm_wdata = wd;
      mm_if.mm_wstrb = ws;
      for (int c = 1; c <= n_cyc; c++) begin
         @(posedge clk); #1;
         if (mm_if.mm_gnt) begin gnt_cnt++; if (gnt_at < 0) gnt_at = c; end
         if (mm_if.mm_rvalid) begin
            rv_cnt++;
            if (rv_at < 0) rv_at = c;
            rv_line = mm_if.mm_rdata;
         end
         if (c <= 8) begin
            b      = c - 1;
            exp_en = wr ? |ws[b] : 1'b1;
            exp_we = wr ? ws[b] : 4'h0;
            exp_a  = exp_en ? AW'(base + b) : '0;
            obs_a  = exp_en ? sram_addr : '0;
            exp_wd = (wr && exp_en) ? wd[b] : 32'h0;
            obs_wd = (wr && exp_en) ? sram_wdata : 32'h0;
            check($sformatf("sram beat %0d", b), {sram_en, sram_we, obs_a, obs_wd},
                  {exp_en, exp_we, exp_a, exp_wd});
         end else begin
            check($sformatf("sram idle c%0d", c), {sram_en, sram_we}, '0);
         end
         if (!wr && c == 11) check("rdata hold", mm_if.mm_rdata, exp_line);
         if (c == 1 + hold) begin
            mm_if.mm_rden = 1'b0;
            mm_if.mm_wren = 1'b0;
         end
      end
      check("gnt count", gnt_cnt, 1);
      check("gnt cycle", gnt_at, 1);
      if (wr) begin
         check("rvalid on write", rv_cnt, 0);
         for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++)
               if (ws[i][k]) ref_mem[base + i][8*k +: 8] = wd[i][8*k +: 8];
      end else begin
         check("rvalid count", rv_cnt, 1);
         check("rvalid cycle", rv_at, 10);
         check("rdata line", rv_line, exp_line);
         last_rdata = rv_line;
      end
   endtask

   initial begin
      logic [7:0][31:0] wd;
      logic [7:0][3:0]  ws;
      logic [31:0]      addr;
      int               kind, n_bad;

      rst = 1'b1;
      bd_en = 1'b0; bd_addr = '0; bd_data = '0;
      mm_if.mm_rden = 1'b0; mm_if.mm_wren = 1'b0; mm_if.mm_addr = '0;
      mm_if.mm_wdata = '0; mm_if.mm_wstrb = '0;
      last_rdata = '0;

      for (int i = 0; i < 8; i++) preload(32'h40 + i, 32'hA0 + i);

      // Reset with a read pending: nothing may respond.
      mm_if.mm_rden = 1'b1;
      mm_if.mm_addr = 32'h100;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_quiet($sformatf("reset c%0d", i));
      end
      rst = 1'b0;

      line_txn(1'b1, 1'b0, 32'h100, '0, '0, 0);
      check("preload word 7", last_rdata[7], 32'hA7);

      for (int i = 0; i < 8; i++) begin
         wd[i] = 32'h11111111 * (i + 1);
         ws[i] = 4'hF;
      end
      ws[3] = 4'h3;
      ws[5] = 4'h0;
      line_txn(1'b0, 1'b1, 32'h100, wd, ws, 0);
      line_txn(1'b1, 1'b0, 32'h100, '0, '0, 0);
      check("partial word 3", last_rdata[3], 32'h00004444);
      check("partial word 5", last_rdata[5], 32'h000000A5);

      for (int i = 0; i < 8; i++) wd[i] = $urandom;
      line_txn(1'b1, 1'b1, 32'h200, wd, '1, 0);
      line_txn(1'b1, 1'b0, 32'h200, '0, '0, 0);

      line_txn(1'b1, 1'b0, 32'h100, '0, '0, 3);
      line_txn(1'b1, 1'b0, 32'h200, '0, '0, 0);

      // Reset asserted during cycle 5 of a read.
      mm_if.mm_rden = 1'b1;
      mm_if.mm_addr = 32'h100;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            check("abort gnt", mm_if.mm_gnt, 1'b1);
            mm_if.mm_rden = 1'b0;
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check_quiet("abort reset");
      rst = 1'b0;
      n_bad = 0;
      for (int c = 7; c <= 14; c++) begin
         @(posedge clk); #1;
         if (mm_if.mm_gnt || mm_if.mm_rvalid || sram_en) n_bad++;
      end
      check("abort silent", n_bad, 0);
      check("abort rdata", mm_if.mm_rdata, '0);
      line_txn(1'b1, 1'b0, 32'h100, '0, '0, 0);

      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 2);
         addr = ($urandom & 32'hFFFF0000) | (32'h100 + ($urandom_range(0, 15) << 5))
                | $urandom_range(0, 31);
         for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            ws[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         end
         line_txn(kind != 1, kind != 0, addr, wd, ws, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
